// File: rtl/floor_call_scheduler.sv
// Floor-call scheduler: captures button presses, picks the next floor with SCAN, drives one-hot floor_req.
// Latency: press -> pending after 2 edges; IDLE -> floor_req in 1 edge; arrival -> DWELL_CYCLES dwell + 1 idle cycle.
// Backpressure: none; floor_req is held until floor_pos matches it, and new calls wait in pending.
module floor_call_scheduler #(
    parameter int NUM_FLOORS   = 5,
    parameter int DWELL_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] btn,
    input  logic [NUM_FLOORS-1:0] floor_pos,
    output logic [NUM_FLOORS-1:0] floor_req,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  busy
);

    localparam int IW = $clog2(NUM_FLOORS);
    localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CW-1:0]         DWELL_LOAD = CW'(DWELL_CYCLES - 1);
    localparam logic [NUM_FLOORS-1:0] ONE        = {{(NUM_FLOORS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        DWELL = 2'd2
    } state_t;

    typedef enum logic {
        DIR_UP = 1'b0,
        DIR_DN = 1'b1
    } dir_t;

    state_t                state, state_nxt;
    dir_t                  dir, dir_nxt;
    logic [NUM_FLOORS-1:0] floor_req_nxt;
    logic [NUM_FLOORS-1:0] pending_nxt;
    logic [NUM_FLOORS-1:0] clr_mask;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [IW-1:0]         cur_idx;

    logic [NUM_FLOORS-1:0] btn_s;
    logic [NUM_FLOORS-1:0] btn_q;
    logic [1:0]            hist_vld;
    logic [NUM_FLOORS-1:0] btn_rise;

    logic                  pos_onehot;
    logic [IW-1:0]         pos_idx;

    logic                  at_cur;
    logic                  found_up, found_dn;
    logic [IW-1:0]         up_idx, dn_idx;
    logic [IW-1:0]         sel_idx;
    logic                  sel_flip;

    // Edges are only trusted once btn_q holds a real post-reset sample,
    // so a button held through reset is not mistaken for a new press.
    assign btn_rise = btn_s & ~btn_q & {NUM_FLOORS{hist_vld[1]}};

    always_comb begin
        pos_onehot = (floor_pos != '0) && ((floor_pos & (floor_pos - ONE)) == '0);
        pos_idx    = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (floor_pos[i]) begin
                pos_idx = IW'(i);
            end
        end
    end

    // Descending scan keeps the lowest index above; ascending keeps the highest below.
    always_comb begin
        at_cur   = pending[cur_idx];
        found_up = 1'b0;
        up_idx   = '0;
        found_dn = 1'b0;
        dn_idx   = '0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (i > int'(cur_idx))) begin
                found_up = 1'b1;
                up_idx   = IW'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (i < int'(cur_idx))) begin
                found_dn = 1'b1;
                dn_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        sel_idx  = cur_idx;
        sel_flip = 1'b0;
        if (!at_cur) begin
            if (dir == DIR_UP) begin
                if (found_up) begin
                    sel_idx = up_idx;
                end else begin
                    sel_idx  = dn_idx;
                    sel_flip = 1'b1;
                end
            end else begin
                if (found_dn) begin
                    sel_idx = dn_idx;
                end else begin
                    sel_idx  = up_idx;
                    sel_flip = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        dir_nxt       = dir;
        floor_req_nxt = floor_req;
        cnt_nxt       = cnt;
        clr_mask      = '0;
        case (state)
            IDLE: begin
                if (pending != '0) begin
                    floor_req_nxt = ONE << sel_idx;
                    state_nxt     = SERVE;
                    if (sel_flip) begin
                        dir_nxt = (dir == DIR_UP) ? DIR_DN : DIR_UP;
                    end
                end else begin
                    floor_req_nxt = '0;
                end
            end
            SERVE: begin
                if (floor_pos == floor_req) begin
                    clr_mask      = floor_req;
                    floor_req_nxt = '0;
                    cnt_nxt       = DWELL_LOAD;
                    state_nxt     = DWELL;
                end
            end
            DWELL: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            default: begin
                state_nxt     = IDLE;
                floor_req_nxt = '0;
            end
        endcase
        // A press landing on the floor being served is dropped with the clear.
        pending_nxt = (pending | btn_rise) & ~clr_mask;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            dir       <= DIR_UP;
            floor_req <= '0;
            pending   <= '0;
            busy      <= 1'b0;
            cnt       <= '0;
            cur_idx   <= '0;
            btn_s     <= '0;
            btn_q     <= '0;
            hist_vld  <= '0;
        end else begin
            state     <= state_nxt;
            dir       <= dir_nxt;
            floor_req <= floor_req_nxt;
            pending   <= pending_nxt;
            busy      <= (state_nxt != IDLE);
            cnt       <= cnt_nxt;
            btn_s     <= btn;
            btn_q     <= btn_s;
            hist_vld  <= {hist_vld[0], 1'b1};
            if (pos_onehot) begin
                cur_idx <= pos_idx;
            end
        end
    end

endmodule

// File: doc/floor_call_scheduler.md
# floor_call_scheduler

Upstream stage of the `Elevator` car controller. Latches floor-button presses into a pending-call register, picks the next target floor with a SCAN (keep-direction) policy, and drives the one-hot `floor_req` bus that `Elevator` consumes. It watches the car's one-hot `floor_pos` to detect arrival, clears the served call, holds a door dwell, then dispatches the next call.

## Interface
- `NUM_FLOORS`, 5: number of floors; width of all floor buses; ≥2.
- `DWELL_CYCLES`, 4: cycles spent in DWELL after each arrival; ≥1.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted at 0).
- `btn`  in  NUM_FLOORS  raw call buttons, bit i = floor i+1; synchronous to `clk`, level-held.
- `floor_pos`  in  NUM_FLOORS  one-hot current car floor from `Elevator`.
- `floor_req`  out  NUM_FLOORS  registered one-hot target to `Elevator`; 0 = no request.
- `pending`  out  NUM_FLOORS  registered outstanding-call lamps.
- `busy`  out  1  registered; 1 when state ≠ IDLE.

## Operation
- Reset values: `floor_req`=0, `pending`=0, `busy`=0, state=IDLE, direction=UP, `cur_idx`=0, dwell counter=0, btn history=0.
- Call capture: a rising edge on `btn[i]` (previous sample 0, current 1) sets `pending[i]`. A held button sets the bit only once.
- Position tracking: `cur_idx` loads the index of `floor_pos` only when `floor_pos` is exactly one-hot. A zero or multi-hot value leaves `cur_idx` unchanged.
- FSM states: IDLE, SERVE, DWELL.
- IDLE with `pending`≠0 selects a target and enters SERVE. The target is loaded into `floor_req`. Selection order:
  1. A pending call at `cur_idx` is chosen first.
  2. If direction is UP, choose the lowest pending index above `cur_idx`. If direction is DOWN, choose the highest pending index below `cur_idx`.
  3. If no call exists in the current direction, flip direction and choose the nearest pending call on the other side.
- IDLE with `pending`=0: stay in IDLE; `floor_req`=0.
- SERVE: hold `floor_req` constant. When `floor_pos` == `floor_req`:
  - clear that `pending` bit;
  - set `floor_req`=0;
  - load the dwell counter with DWELL_CYCLES−1;
  - enter DWELL.
- DWELL: decrement the counter each cycle. When the counter is 0, return to IDLE.
- Simultaneous events:
  - A press on the floor being cleared in the same cycle is dropped, because the car is already there.
  - Presses on other floors are captured in every state.
  - A re-press of the current target has no effect.
- New calls never preempt the target while in SERVE. The target is re-evaluated only in IDLE.
- Asserting reset mid-operation returns everything to reset values immediately (asynchronous); all pending calls are lost.

## Timing
- Rising edge of `btn[i]` sampled at edge N → `pending[i]`=1 after edge N+1. The history register adds one cycle.
- IDLE with `pending`≠0 at edge N → `floor_req` valid and `busy`=1 after edge N.
- Arrival match sampled at edge N:
  - `floor_req`=0 and the `pending` bit cleared after edge N;
  - DWELL occupies exactly DWELL_CYCLES cycles;
  - IDLE for one cycle;
  - next `floor_req` valid on the following edge.
- Call at the car's current floor while idle: `floor_req` is asserted for at least one cycle. The match happens on the next edge.
- `floor_req` is never multi-hot. It changes only on entering SERVE (set) or leaving SERVE (clear).

## Test plan
NUM_FLOORS=5, DWELL_CYCLES=4.
- Reset: hold `reset`=0 for 2 cycles while `btn`=5'b11111 → all outputs 0. Release; `btn` still held → no `pending` bits set (no rising edge).
- Single call: car at 5'b00001; pulse `btn`=5'b00100 → `pending`=5'b00100, then `floor_req`=5'b00100, `busy`=1. Drive `floor_pos`=5'b00100 → `floor_req`=0, `pending`=0, `busy` stays 1 for 4 cycles, then 0.
- SCAN order: car at floor 3 (5'b00100), direction UP; press floors 2, 5, 4 together (5'b11010) → targets issued in order 5'b01000, 5'b10000, then 5'b00010 (direction flips).
- Current-floor call: car at 5'b01000, idle; press 5'b01000 → `floor_req`=5'b01000 for one cycle, then cleared and DWELL entered.
- Clear-vs-press collision: in SERVE with target 5'b00010, re-press 5'b00010 in the same cycle as the arrival match → `pending[1]`=0 afterwards. A press of 5'b10000 during DWELL → `pending[4]`=1 and dispatched after DWELL.
- Async reset mid-SERVE: assert `reset`=0 between clock edges → `floor_req`, `pending`, `busy` go to 0 immediately, without waiting for a clock edge.
